// File: rtl/swap_round_sequencer_pkg.sv
// Shared types and constants for the swap round sequencer.
// Contents:
//   BYTE_W       width of the permuted datum
//   swap_pair_t  one key-table entry (two bit positions to exchange)
//   seq_state_t  sequencer FSM states
package swap_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef struct packed {
    logic [2:0] pos1;
    logic [2:0] pos2;
  } swap_pair_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/swap_round_sequencer_if.sv
// Byte stream interface between source, swap round sequencer and downstream stages.
// Signals:
//   in_valid/in_ready     input handshake; in_data byte, in_decrypt direction
//   out_valid/out_ready   output handshake; out_data permuted byte
// Modports: master = environment side, slave = sequencer side.
interface swap_round_sequencer_if;
  import swap_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_data;
  logic              in_decrypt;
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_decrypt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_decrypt, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/swap_round_sequencer_bit_pair_swap.sv
// Combinational exchange of two bit positions within a byte.
// Ports:
//   byte_in   source byte
//   pos1      first bit position
//   pos2      second bit position
//   byte_out  byte_in with bits pos1 and pos2 exchanged (unchanged if pos1 == pos2)
module bit_pair_swap
  import swap_pkg::*;
(
  input  logic [BYTE_W-1:0] byte_in,
  input  logic [2:0]        pos1,
  input  logic [2:0]        pos2,
  output logic [BYTE_W-1:0] byte_out
);

  always_comb begin
    byte_out       = byte_in;
    byte_out[pos1] = byte_in[pos2];
    byte_out[pos2] = byte_in[pos1];
  end

endmodule

// File: rtl/swap_round_sequencer.sv
// One permutation round: applies a programmable chain of bit-pair swaps to a byte,
// one swap per clock, forward order for encrypt and reverse order for decrypt.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   bus               byte stream interface (slave modport)
//   key_we/key_idx    key-table write strobe and entry index (honoured in IDLE only)
//   key_pos1/key_pos2 bit positions written into the entry
//   busy              high while a round is in RUN or DONE
//   byte_count        completed output handshakes (only with SWAP_BYTE_COUNT_EN)
// Build option: define SWAP_BYTE_COUNT_EN to add the byte_count output.
module swap_round_sequencer
  import swap_pkg::*;
#(
  parameter int unsigned NUM_SWAPS = 8,
  parameter int unsigned IDX_W     = (NUM_SWAPS > 1) ? $clog2(NUM_SWAPS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  swap_round_sequencer_if.slave  bus,
  input  logic                   key_we,
  input  logic [IDX_W-1:0]       key_idx,
  input  logic [2:0]             key_pos1,
  input  logic [2:0]             key_pos2,
  output logic                   busy
`ifdef SWAP_BYTE_COUNT_EN
  ,
  output logic [15:0]            byte_count
`endif
);

  localparam logic [IDX_W-1:0] LastStep = IDX_W'(NUM_SWAPS - 1);

  seq_state_t        state_q, state_d;
  logic [BYTE_W-1:0] work_q, work_d;
  logic [IDX_W-1:0]  step_q, step_d;
  logic              dir_q, dir_d;
  swap_pair_t        table_q [NUM_SWAPS];
  logic [BYTE_W-1:0] swapped;
  logic              accept;
  logic              key_commit;

  bit_pair_swap u_swap (
    .byte_in  (work_q),
    .pos1     (table_q[step_q].pos1),
    .pos2     (table_q[step_q].pos2),
    .byte_out (swapped)
  );

  assign accept     = (state_q == IDLE) && bus.in_valid;
  assign key_commit = (state_q == IDLE) && key_we && (32'(key_idx) < NUM_SWAPS);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    step_d  = step_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_data;
          dir_d   = bus.in_decrypt;
          step_d  = bus.in_decrypt ? LastStep : '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d = swapped;
        if (!dir_q) begin
          if (step_q == LastStep) state_d = DONE;
          else                    step_d  = step_q + 1'b1;
        end else begin
          if (step_q == '0) state_d = DONE;
          else              step_d  = step_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      step_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
    end
  end

  // A write in the accept cycle lands before the first RUN read, so the round sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SWAPS); i++) table_q[i] <= '0;
    end else if (key_commit) begin
      table_q[key_idx] <= '{pos1: key_pos1, pos2: key_pos2};
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = (state_q == DONE) ? work_q : '0;
  assign busy          = (state_q != IDLE);

  logic unused_accept;
  assign unused_accept = accept;

`ifdef SWAP_BYTE_COUNT_EN
  logic [15:0] count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 count_q <= '0;
    else if ((state_q == DONE) && bus.out_ready) count_q <= count_q + 16'd1;
  end
  assign byte_count = count_q;
`endif

endmodule

// File: tb/tb_swap_round_sequencer.sv
module tb_swap_round_sequencer;
  import swap_pkg::*;

  logic       clk;
  logic       rst;
  logic       key_we;
  logic [2:0] key_idx;
  logic [2:0] key_pos1;
  logic [2:0] key_pos2;
  logic       busy;
`ifdef SWAP_BYTE_COUNT_EN
  logic [15:0] byte_count;
  int          exp_count;
`endif

  int n_checks;
  int n_fail;

  swap_round_sequencer_if bus_if ();

  swap_round_sequencer #(.NUM_SWAPS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if.slave),
    .key_we     (key_we),
    .key_idx    (key_idx),
    .key_pos1   (key_pos1),
    .key_pos2   (key_pos2),
    .busy       (busy)
`ifdef SWAP_BYTE_COUNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input int idx, input int p1, input int p2);
    key_we   = 1'b1;
    key_idx  = 3'(idx);
    key_pos1 = 3'(p1);
    key_pos2 = 3'(p2);
    step_clk();
    key_we   = 1'b0;
  endtask

  // Accept a byte, wait (bounded) for out_valid, then complete the handshake.
  task automatic run_round(input logic [7:0] din, input logic dec,
                           output logic [7:0] dout, output int lat);
    bus_if.in_valid   = 1'b1;
    bus_if.in_data    = din;
    bus_if.in_decrypt = dec;
    step_clk();
    bus_if.in_valid = 1'b0;
    lat = 0;
    while (!bus_if.out_valid && lat < 100) begin
      step_clk();
      lat++;
    end
    dout = bus_if.out_data;
    bus_if.out_ready = 1'b1;
    step_clk();
    bus_if.out_ready = 1'b0;
`ifdef SWAP_BYTE_COUNT_EN
    exp_count++;
`endif
  endtask

  initial begin
    logic [7:0] res;
    int         lat;
    n_checks = 0;
    n_fail   = 0;
`ifdef SWAP_BYTE_COUNT_EN
    exp_count = 0;
`endif
    rst               = 1'b1;
    key_we            = 1'b0;
    key_idx           = '0;
    key_pos1          = '0;
    key_pos2          = '0;
    bus_if.in_valid   = 1'b0;
    bus_if.in_data    = '0;
    bus_if.in_decrypt = 1'b0;
    bus_if.out_ready  = 1'b0;
    step_clk();
    step_clk();

    check("reset_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("reset_out_data", 32'(bus_if.out_data), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step_clk();

    // 0=(7,0), 1=(6,1): 0x33 -> 0xB2 -> 0xF0
    write_key(0, 7, 0);
    write_key(1, 6, 1);
    run_round(8'h33, 1'b0, res, lat);
    check("enc_33", 32'(res), 32'hF0);
    check("latency", 32'(lat), 32'd8);
    check("idle_after_hs", 32'(bus_if.in_ready), 32'd1);
    run_round(8'hF0, 1'b1, res, lat);
    check("dec_F0", 32'(res), 32'h33);
    check("dec_latency", 32'(lat), 32'd8);

    // 0=(0,1), 1=(1,2): forward 0x01 -> 0x02 -> 0x04; reverse undoes it
    write_key(0, 0, 1);
    write_key(1, 1, 2);
    run_round(8'h01, 1'b0, res, lat);
    check("enc_01", 32'(res), 32'h04);
    run_round(8'h04, 1'b1, res, lat);
    check("dec_04", 32'(res), 32'h01);
    run_round(8'hA5, 1'b0, res, lat);
    check("enc_A5", 32'(res), 32'hA6);
    run_round(res, 1'b1, res, lat);
    check("roundtrip_A5", 32'(res), 32'hA5);

    // Backpressure in DONE
    bus_if.in_valid   = 1'b1;
    bus_if.in_data    = 8'h01;
    bus_if.in_decrypt = 1'b0;
    step_clk();
    bus_if.in_valid = 1'b0;
    lat = 0;
    while (!bus_if.out_valid && lat < 100) begin
      step_clk();
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", 32'(bus_if.out_valid), 32'd1);
      check("hold_out_data", 32'(bus_if.out_data), 32'h04);
      check("hold_in_ready", 32'(bus_if.in_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
      step_clk();
    end
    bus_if.out_ready = 1'b1;
    step_clk();
    bus_if.out_ready = 1'b0;
`ifdef SWAP_BYTE_COUNT_EN
    exp_count++;
`endif
    check("hs_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("hs_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);

    // Key write during RUN is dropped; (3,4) would turn 0x01 into 0x01
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h01;
    step_clk();
    bus_if.in_valid = 1'b0;
    step_clk();
    write_key(0, 3, 4);
    lat = 0;
    while (!bus_if.out_valid && lat < 100) begin
      step_clk();
      lat++;
    end
    check("run_write_ignored", 32'(bus_if.out_data), 32'h04);
    bus_if.out_ready = 1'b1;
    step_clk();
    bus_if.out_ready = 1'b0;
`ifdef SWAP_BYTE_COUNT_EN
    exp_count++;
`endif
    run_round(8'h01, 1'b0, res, lat);
    check("old_entry_kept", 32'(res), 32'h04);

    // Same-cycle key write and accept: new entry used
    key_we          = 1'b1;
    key_idx         = 3'd0;
    key_pos1        = 3'd3;
    key_pos2        = 3'd4;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h08;
    step_clk();
    key_we          = 1'b0;
    bus_if.in_valid = 1'b0;
    lat = 0;
    while (!bus_if.out_valid && lat < 100) begin
      step_clk();
      lat++;
    end
    check("same_cycle_write", 32'(bus_if.out_data), 32'h10);
    bus_if.out_ready = 1'b1;
    step_clk();
    bus_if.out_ready = 1'b0;
`ifdef SWAP_BYTE_COUNT_EN
    exp_count++;
`endif

    // Reset on the 3rd RUN cycle
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h77;
    step_clk();
    bus_if.in_valid = 1'b0;
    step_clk();
    step_clk();
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    step_clk();
    rst = 1'b0;
`ifdef SWAP_BYTE_COUNT_EN
    exp_count = 0;
    check("count_after_rst", 32'(byte_count), 32'd0);
`endif
    step_clk();
    run_round(8'h5A, 1'b0, res, lat);
    check("post_rst_5A", 32'(res), 32'h5A);
    run_round(8'h08, 1'b0, res, lat);
    check("post_rst_identity", 32'(res), 32'h08);
    run_round(8'h02, 1'b1, res, lat);
    check("post_rst_dec_02", 32'(res), 32'h02);

`ifdef SWAP_BYTE_COUNT_EN
    check("byte_count", 32'(byte_count), 32'(exp_count));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
